cache_status_memory: RTL and testbench
======================================

# cache_status_memory

Per-set status storage for the set-associative caches: one valid bit, plus an optional dirty bit, per way, held for every cache set. It provides one write port and two independent registered read ports. A built-in sweep engine clears all status bits after reset or on a flush request, replacing power-on initialisation. The block sits beside the tag and data arrays in each cache controller.

## Interface
Parameters:
- ADDR_WIDTH, 8, set index width; DEPTH = 2**ADDR_WIDTH sets
- WAYS, 2, number of ways; one status bit per way per field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- write_i  in  1  write strobe
- write_address_i  in  ADDR_WIDTH  set index to write
- write_way_i  in  WAYS  way mask; every set bit is written
- valid_i  in  1  valid value written to the masked ways
- dirty_i  in  1  dirty value written to the masked ways (DIRTY_BIT_EN only)
- read_i  in  2  per-port read strobe
- read_address_0_i / read_address_1_i  in  ADDR_WIDTH  read port set indices
- valid_0_o / valid_1_o  out  WAYS  registered valid bits of the read set
- dirty_0_o / dirty_1_o  out  WAYS  registered dirty bits (DIRTY_BIT_EN only)
- flush_i  in  1  request to invalidate every set
- busy_o  out  1  sweep in progress; requests are ignored while high
- flush_done_o  out  1  one-cycle pulse when a sweep completes

## Operation
- FSM states:
  - IDLE: normal operation.
  - SWEEP: a sweep counter walks sets 0..DEPTH-1, one set per cycle. For each set, the valid and dirty bits of all ways are cleared.
  - DONE: lasts one cycle, then returns to IDLE.
- Reset: asserting rst_i forces state SWEEP with counter 0, asynchronously.
  - All outputs reset to 0, except busy_o, which resets to 1.
  - Reset asserted during a sweep restarts the sweep from set 0.
- IDLE plus flush_i: go to SWEEP with counter 0. A write in the same cycle is dropped.
- SWEEP, counter == DEPTH-1: clear that set, then go to DONE.
- Writes: in IDLE or DONE, write_i updates the masked ways of write_address_i.
  - Unmasked ways are unchanged.
  - write_way_i = 0 is a no-op.
- Reads: in IDLE or DONE, read_i[n] loads port n's output registers from read_address_n_i.
  - Outputs hold their last value when the strobe is low.
- Collisions:
  - A read and a write to the same set in the same cycle return the pre-write contents (read-first).
  - Both ports may read the same set.
- In SWEEP: write_i, read_i and flush_i are ignored, and read outputs hold.
- flush_i asserted while busy_o is high is dropped, not queued.

## Timing
- Read latency is 1 cycle: read_i sampled at edge t gives data valid after edge t.
- Write latency is 1 cycle: a read at edge t+1 observes a write sampled at edge t.
- Flush sampled at edge t:
  - busy_o is high after edges t .. t+DEPTH-1.
  - flush_done_o is high for exactly the cycle after edge t+DEPTH.
  - busy_o is low in that same cycle, and new requests are accepted in it.
- After reset release: busy_o is high for DEPTH cycles, then flush_done_o pulses once.
- busy_o = (state == SWEEP) and is registered; there is no combinational path from inputs to outputs.

## Configuration
- CACHE_DIRTY_BIT_EN defined:
  - dirty storage, dirty_i and dirty_0_o/dirty_1_o exist.
  - Writes set the dirty bit alongside valid, and the sweep clears it.
- Undefined: no dirty storage and no dirty ports; the valid path is identical.

## Structure
- cache_status_pkg holds:
  - the status_fsm_t enum (IDLE, SWEEP, DONE);
  - the status_t struct (valid, plus dirty under the macro).
- Storage is a DEPTH x WAYS array of status_t, written by one port and read by two synchronous ports, so it infers as RAM.
- Sub-module status_sweep_controller holds the FSM, the counter, busy_o and flush_done_o. It drives a clear-enable and a clear address into a write mux in the top level.

## Test plan
- Reset release with ADDR_WIDTH=4 -> busy_o=1 for 16 cycles, flush_done_o pulses once; a read of set 15 then returns valid=0.
- Write set 5, way mask 2'b10, valid=1; read port 0 of set 5 next cycle -> valid_0_o=2'b10.
- Same-cycle write of set 3 (valid=1) and port 1 read of set 3 -> valid_1_o=0; a read the next cycle -> 2'b11 for mask 2'b11.
- Fill all sets, pulse flush_i together with write_i -> the write is dropped, busy_o=1 for DEPTH cycles; every set then reads 0, and dirty reads 0 with CACHE_DIRTY_BIT_EN.
- Assert rst_i at sweep counter 7 -> busy_o stays 1, the sweep restarts from set 0, and flush_done_o comes DEPTH cycles after release.
- flush_i during SWEEP, or reads during SWEEP -> ignored: a single flush_done_o pulse, and read outputs unchanged.

Source files
------------

// File: rtl/cache_status_pkg.sv
// Shared types for the cache status memory: sweep FSM states and per-way status record.
// Dirty field present only when CACHE_DIRTY_BIT_EN is defined.
package cache_status_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } status_fsm_t;

  typedef struct packed {
    logic valid;
`ifdef CACHE_DIRTY_BIT_EN
    logic dirty;
`endif
  } status_t;

endpackage

// File: rtl/status_sweep_controller.sv
// Sweep engine: walks every set once after reset or an accepted flush, driving a clear
// port into the status array. Owns busy_o and the flush_done_o pulse.
module status_sweep_controller
  import cache_status_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = '1;

  status_fsm_t           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE behaves like IDLE for requests; it only adds the one-cycle pulse
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (flush_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SET) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign flush_done_o = done_q;
  assign clr_en_o     = (state_q == SWEEP);
  assign clr_addr_o   = cnt_q;

endmodule

// File: rtl/cache_status_memory.sv
// Per-set, per-way status array (valid, plus dirty with CACHE_DIRTY_BIT_EN) with one write
// port, two registered read ports and a sweep engine that clears all sets after reset/flush.
module cache_status_memory
  import cache_status_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WAYS       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] write_address_i,
  input  logic [WAYS-1:0]       write_way_i,
  input  logic                  valid_i,
`ifdef CACHE_DIRTY_BIT_EN
  input  logic                  dirty_i,
  output logic [WAYS-1:0]       dirty_0_o,
  output logic [WAYS-1:0]       dirty_1_o,
`endif
  input  logic [1:0]            read_i,
  input  logic [ADDR_WIDTH-1:0] read_address_0_i,
  input  logic [ADDR_WIDTH-1:0] read_address_1_i,
  output logic [WAYS-1:0]       valid_0_o,
  output logic [WAYS-1:0]       valid_1_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  status_t               mem_q [DEPTH][WAYS];
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;
  logic                  wr_en;
  logic [1:0]            rd_en;
  status_t               wr_data;

  status_sweep_controller #(.ADDR_WIDTH(ADDR_WIDTH)) u_sweep (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .busy_o       (busy),
    .flush_done_o (flush_done_o),
    .clr_en_o     (clr_en),
    .clr_addr_o   (clr_addr)
  );

  assign busy_o = busy;
  // A flush accepted in the same cycle wins over the write
  assign wr_en  = write_i & ~busy & ~flush_i;
  assign rd_en  = read_i & {2{~busy}};

  always_comb begin
    wr_data       = '0;
    wr_data.valid = valid_i;
`ifdef CACHE_DIRTY_BIT_EN
    wr_data.dirty = dirty_i;
`endif
  end

  // No reset on the array: the sweep is its initialisation
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAYS; w++) begin
      if (clr_en)
        mem_q[clr_addr][w] <= '0;
      else if (wr_en && write_way_i[w])
        mem_q[write_address_i][w] <= wr_data;
    end
  end

  logic [WAYS-1:0] valid_0_q, valid_1_q;
`ifdef CACHE_DIRTY_BIT_EN
  logic [WAYS-1:0] dirty_0_q, dirty_1_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_0_q <= '0;
      valid_1_q <= '0;
`ifdef CACHE_DIRTY_BIT_EN
      dirty_0_q <= '0;
      dirty_1_q <= '0;
`endif
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (rd_en[0]) begin
          valid_0_q[w] <= mem_q[read_address_0_i][w].valid;
`ifdef CACHE_DIRTY_BIT_EN
          dirty_0_q[w] <= mem_q[read_address_0_i][w].dirty;
`endif
        end
        if (rd_en[1]) begin
          valid_1_q[w] <= mem_q[read_address_1_i][w].valid;
`ifdef CACHE_DIRTY_BIT_EN
          dirty_1_q[w] <= mem_q[read_address_1_i][w].dirty;
`endif
        end
      end
    end
  end

  assign valid_0_o = valid_0_q;
  assign valid_1_o = valid_1_q;
`ifdef CACHE_DIRTY_BIT_EN
  assign dirty_0_o = dirty_0_q;
  assign dirty_1_o = dirty_1_q;
`endif

endmodule

// File: tb/tb_cache_status_memory.sv
// Directed bench for cache_status_memory (ADDR_WIDTH=4, WAYS=2), dirty checks under CACHE_DIRTY_BIT_EN.
module tb_cache_status_memory;

  localparam int AW    = 4;
  localparam int WAYS  = 2;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            write_i;
  logic [AW-1:0]   write_address_i;
  logic [WAYS-1:0] write_way_i;
  logic            valid_i;
  logic            dirty_i;
  logic [1:0]      read_i;
  logic [AW-1:0]   read_address_0_i, read_address_1_i;
  logic [WAYS-1:0] valid_0_o, valid_1_o;
  logic [WAYS-1:0] dirty_0_o, dirty_1_o;
  logic            flush_i;
  logic            busy_o;
  logic            flush_done_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_status_memory #(.ADDR_WIDTH(AW), .WAYS(WAYS)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .write_i          (write_i),
    .write_address_i  (write_address_i),
    .write_way_i      (write_way_i),
    .valid_i          (valid_i),
`ifdef CACHE_DIRTY_BIT_EN
    .dirty_i          (dirty_i),
    .dirty_0_o        (dirty_0_o),
    .dirty_1_o        (dirty_1_o),
`endif
    .read_i           (read_i),
    .read_address_0_i (read_address_0_i),
    .read_address_1_i (read_address_1_i),
    .valid_0_o        (valid_0_o),
    .valid_1_o        (valid_1_o),
    .flush_i          (flush_i),
    .busy_o           (busy_o),
    .flush_done_o     (flush_done_o)
  );

`ifndef CACHE_DIRTY_BIT_EN
  assign dirty_0_o = '0;
  assign dirty_1_o = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_i = 0; write_address_i = '0; write_way_i = '0; valid_i = 0; dirty_i = 0;
    read_i = '0; read_address_0_i = '0; read_address_1_i = '0; flush_i = 0;
  endtask

  // From the current (busy) cycle, count edges until flush_done_o; returns edge count and busy samples.
  task automatic wait_done(output int edges, output int nbusy);
    edges = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy_o) nbusy++;
      if (flush_done_o) begin edges = k; break; end
    end
  endtask

  int edges, nbusy, pulses;

  initial begin
    idle_inputs();
    rst = 1;
    #3;
    check("reset_busy", 32'(busy_o), 32'd1);
    check("reset_done", 32'(flush_done_o), 32'd0);
    check("reset_valid0", 32'(valid_0_o), 32'd0);
    check("reset_valid1", 32'(valid_1_o), 32'd0);
    step();
    rst = 0;
    check("release_busy", 32'(busy_o), 32'd1);
    // 16 busy cycles: this one plus 15 more; done after edge 16
    wait_done(edges, nbusy);
    check("init_done_edge", 32'(edges), 32'd16);
    check("init_busy_cycles", 32'(nbusy + 1), 32'd16);
    check("init_busy_low_at_done", 32'(busy_o), 32'd0);

    // Requests accepted in the DONE cycle
    write_i = 1; write_address_i = 4'd9; write_way_i = 2'b01; valid_i = 1; dirty_i = 1;
    read_i = 2'b01; read_address_0_i = 4'd15;
    step();
    idle_inputs();
    check("done_single_pulse", 32'(flush_done_o), 32'd0);
    check("read_set15_after_sweep", 32'(valid_0_o), 32'd0);
    read_i = 2'b10; read_address_1_i = 4'd9;
    step();
    check("write_in_done_cycle", 32'(valid_1_o), 32'h1);
    check("write_in_done_dirty", 32'(dirty_1_o), `ifdef CACHE_DIRTY_BIT_EN 32'h1 `else 32'h0 `endif);

    // Masked write
    idle_inputs();
    write_i = 1; write_address_i = 4'd5; write_way_i = 2'b10; valid_i = 1;
    step();
    idle_inputs();
    read_i = 2'b01; read_address_0_i = 4'd5;
    step();
    check("mask10_write", 32'(valid_0_o), 32'h2);
    write_i = 1; write_address_i = 4'd5; write_way_i = 2'b01; valid_i = 1;
    step();
    write_way_i = 2'b00; valid_i = 0;
    step();
    idle_inputs();
    read_i = 2'b01; read_address_0_i = 4'd5;
    step();
    check("unmasked_kept_mask0_noop", 32'(valid_0_o), 32'h3);

    // Read-first collision on port 1
    idle_inputs();
    write_i = 1; write_address_i = 4'd3; write_way_i = 2'b11; valid_i = 1;
    read_i = 2'b10; read_address_1_i = 4'd3;
    step();
    check("collision_read_first", 32'(valid_1_o), 32'h0);
    idle_inputs();
    read_i = 2'b10; read_address_1_i = 4'd3;
    step();
    check("collision_next_read", 32'(valid_1_o), 32'h3);

    // Outputs hold with strobes low, both ports on one set
    idle_inputs();
    read_address_0_i = 4'd0; read_address_1_i = 4'd0;
    step();
    check("hold_port0", 32'(valid_0_o), 32'h3);
    check("hold_port1", 32'(valid_1_o), 32'h3);
    read_i = 2'b11; read_address_0_i = 4'd9; read_address_1_i = 4'd9;
    step();
    check("same_set_port0", 32'(valid_0_o), 32'h1);
    check("same_set_port1", 32'(valid_1_o), 32'h1);

    // Fill everything, then flush with a colliding write
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      write_i = 1; write_address_i = AW'(i); write_way_i = 2'b11; valid_i = 1; dirty_i = 1;
      step();
    end
    idle_inputs();
    read_i = 2'b11; read_address_0_i = 4'd7; read_address_1_i = 4'd12;
    step();
    check("filled_port0", 32'(valid_0_o), 32'h3);
    check("filled_port1_dirty", 32'(dirty_1_o), `ifdef CACHE_DIRTY_BIT_EN 32'h3 `else 32'h0 `endif);
    idle_inputs();
    flush_i = 1; write_i = 1; write_address_i = 4'd2; write_way_i = 2'b11; valid_i = 1;
    step();
    check("flush_busy_first", 32'(busy_o), 32'd1);
    // Requests during the sweep must be ignored
    idle_inputs();
    edges = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin flush_i = 1; read_i = 2'b11; write_i = 1; write_way_i = 2'b11; valid_i = 1; end
      else idle_inputs();
      step();
      if (busy_o) nbusy++;
      if (flush_done_o) begin edges = k; break; end
    end
    idle_inputs();
    check("flush_done_edge", 32'(edges), 32'd16);
    check("flush_busy_cycles", 32'(nbusy + 1), 32'd16);
    check("sweep_read_hold0", 32'(valid_0_o), 32'h3);
    check("sweep_read_hold1", 32'(valid_1_o), 32'h3);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (flush_done_o) pulses++;
    end
    check("no_extra_done", 32'(pulses), 32'd0);
    check("idle_after_flush", 32'(busy_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      read_i = 2'b11; read_address_0_i = AW'(i); read_address_1_i = AW'(DEPTH - 1 - i);
      step();
      check($sformatf("flushed_v0_set%0d", i), 32'({valid_0_o, valid_1_o}), 32'h0);
      check($sformatf("flushed_d_set%0d", i), 32'({dirty_0_o, dirty_1_o}), 32'h0);
    end

    // Reset mid-sweep at counter 7
    idle_inputs();
    write_i = 1; write_address_i = 4'd1; write_way_i = 2'b11; valid_i = 1;
    step();
    idle_inputs();
    read_i = 2'b01; read_address_0_i = 4'd1;
    step();
    check("pre_reset_read", 32'(valid_0_o), 32'h3);
    idle_inputs();
    flush_i = 1;
    step();
    idle_inputs();
    for (int k = 0; k < 7; k++) step();
    check("counter7_busy", 32'(busy_o), 32'd1);
    #2 rst = 1;
    #1;
    check("midsweep_reset_busy", 32'(busy_o), 32'd1);
    check("midsweep_reset_outputs", 32'(valid_0_o), 32'h0);
    step();
    rst = 0;
    wait_done(edges, nbusy);
    check("restart_done_edge", 32'(edges), 32'd16);
    check("restart_busy_cycles", 32'(nbusy + 1), 32'd16);
    idle_inputs();
    read_i = 2'b01; read_address_0_i = 4'd1;
    step();
    check("restart_cleared_set1", 32'(valid_0_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
